// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target and its bus front end.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } i2c_tgt_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h13;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA and derives SCL edge pulses plus START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl = scl_sync[SYNC_STAGES-1];
    assign sda = sda_sync[SYNC_STAGES-1];

    assign scl_rise  = scl & ~scl_prev;
    assign scl_fall  = ~scl & scl_prev;
    // SDA edges only count as bus conditions when SCL is stable high.
    assign start_det = scl & scl_prev & sda_prev & ~sda;
    assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target responder: address match, write-byte streaming, read-byte serving.
// Optional clock stretching on read-data underrun with I2C_TGT_STRETCH_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       I2C_SCL_i,
    input  logic       I2C_SDA_i,
    output logic       I2C_SCL_o,
    output logic       I2C_SDA_o,
    output logic [7:0] rxData,
    output logic       rxValid,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReq,
    output logic       selected,
    output logic       rwDir,
    output logic       startDet,
    output logic       stopDet,
    output logic       nackRx
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (I2C_SCL_i),
        .sda_in    (I2C_SDA_i),
        .sda       (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_tgt_state_t state;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;
    logic [7:0]     shift_in;
    logic           ack_on;
    logic           tx_pend;
    logic           scl_hold;
    logic           tx_ready;

    assign shift_in = {shreg[6:0], sda_s};

`ifdef I2C_TGT_STRETCH_EN
    assign tx_ready  = txValid;
    assign I2C_SCL_o = ~scl_hold;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = txValid;
    assign tx_ready        = 1'b1;
    assign I2C_SCL_o       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            ack_on    <= 1'b0;
            tx_pend   <= 1'b0;
            scl_hold  <= 1'b0;
            I2C_SDA_o <= 1'b1;
            rxValid   <= 1'b0;
            txReq     <= 1'b0;
            startDet  <= 1'b0;
            stopDet   <= 1'b0;
            nackRx    <= 1'b0;
            selected  <= 1'b0;
            rwDir     <= 1'b0;
            if (rst)
                rxData <= '0;
        end else begin
            rxValid  <= 1'b0;
            txReq    <= 1'b0;
            startDet <= 1'b0;
            stopDet  <= 1'b0;
            nackRx   <= 1'b0;
            // STOP outranks START if a glitch ever raises both together.
            if (stop_det) begin
                state     <= IDLE;
                stopDet   <= 1'b1;
                selected  <= 1'b0;
                ack_on    <= 1'b0;
                tx_pend   <= 1'b0;
                scl_hold  <= 1'b0;
                I2C_SDA_o <= 1'b1;
            end else if (start_det) begin
                state     <= ADDR;
                startDet  <= 1'b1;
                bit_cnt   <= '0;
                selected  <= 1'b0;
                ack_on    <= 1'b0;
                tx_pend   <= 1'b0;
                scl_hold  <= 1'b0;
                I2C_SDA_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: if (scl_rise) begin
                        shreg   <= shift_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (shift_in[7:1] == TARGET_ADDR) begin
                                state    <= ADDR_ACK;
                                ack_on   <= 1'b0;
                                selected <= 1'b1;
                                rwDir    <= shift_in[0];
                                if (shift_in[0]) begin
                                    if (tx_ready) begin
                                        txReq <= 1'b1;
                                        shreg <= txData;
                                    end else begin
                                        tx_pend <= 1'b1;
                                    end
                                end
                            end else begin
                                state <= IGNORE;
                            end
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            I2C_SDA_o <= I2C_ACK;
                            ack_on    <= 1'b1;
                        end else begin
                            ack_on <= 1'b0;
                            if (rwDir) begin
                                state <= READ;
                                if (tx_pend) begin
                                    I2C_SDA_o <= 1'b1;
                                    scl_hold  <= 1'b1;
                                    bit_cnt   <= '0;
                                end else begin
                                    I2C_SDA_o <= shreg[7];
                                    shreg     <= {shreg[6:0], 1'b0};
                                    bit_cnt   <= 4'd1;
                                end
                            end else begin
                                I2C_SDA_o <= 1'b1;
                                state     <= WRITE;
                                bit_cnt   <= '0;
                            end
                        end
                    end
                    WRITE: if (scl_rise) begin
                        shreg   <= shift_in;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            rxData  <= shift_in;
                            rxValid <= 1'b1;
                            state   <= WRITE_ACK;
                            ack_on  <= 1'b0;
                        end
                    end
                    WRITE_ACK: if (scl_fall) begin
                        if (!ack_on) begin
                            I2C_SDA_o <= I2C_ACK;
                            ack_on    <= 1'b1;
                        end else begin
                            I2C_SDA_o <= 1'b1;
                            ack_on    <= 1'b0;
                            state     <= WRITE;
                            bit_cnt   <= '0;
                        end
                    end
                    READ: begin
                        // While a byte is still pending, SCL is held low until fabric supplies it.
                        if (tx_pend) begin
                            if (scl_hold && tx_ready) begin
                                txReq     <= 1'b1;
                                tx_pend   <= 1'b0;
                                scl_hold  <= 1'b0;
                                I2C_SDA_o <= txData[7];
                                shreg     <= {txData[6:0], 1'b0};
                                bit_cnt   <= 4'd1;
                            end else if (scl_fall) begin
                                scl_hold <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                I2C_SDA_o <= 1'b1;
                                state     <= READ_ACK;
                            end else begin
                                I2C_SDA_o <= shreg[7];
                                shreg     <= {shreg[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    READ_ACK: if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            state   <= READ;
                            bit_cnt <= '0;
                            if (tx_ready) begin
                                txReq <= 1'b1;
                                shreg <= txData;
                            end else begin
                                tx_pend <= 1'b1;
                            end
                        end else begin
                            nackRx <= 1'b1;
                            state  <= IGNORE;
                        end
                    end
                    IGNORE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C controller model drives transactions and
// a transaction-level reference predicts ACKs, written bytes, read bytes and pulses.
module tb_i2c_target;
    import i2c_pkg::*;

    localparam logic [6:0] TGT = 7'h13;
    localparam int         Q   = 8;

    logic       clk = 1'b0;
    logic       rst, enable;
    logic       scl_ctl, sda_ctl;
    logic       scl_line, sda_line;
    logic       I2C_SCL_o, I2C_SDA_o;
    logic [7:0] rxData, txData;
    logic       rxValid, txValid, txReq, selected, rwDir, startDet, stopDet, nackRx;

    int n_vec = 0, n_err = 0;
    int n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0, n_nack = 0;
    int n_viol = 0, n_sda_low = 0;
    int tx_idx = 0, exp_ptr = 0, rx_rd = 0;
    logic       prev_sda = 1'b1;
    logic [7:0] pool   [256];
    logic [7:0] rx_log [256];
    logic [7:0] wr_q   [$];
    logic [7:0] exp_rx [$];

    assign scl_line = scl_ctl & I2C_SCL_o;
    assign sda_line = sda_ctl & I2C_SDA_o;
    assign txData   = pool[8'(tx_idx)];

    i2c_target #(.TARGET_ADDR(TGT), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .I2C_SCL_i (scl_line),
        .I2C_SDA_i (sda_line),
        .I2C_SCL_o (I2C_SCL_o),
        .I2C_SDA_o (I2C_SDA_o),
        .rxData    (rxData),
        .rxValid   (rxValid),
        .txData    (txData),
        .txValid   (txValid),
        .txReq     (txReq),
        .selected  (selected),
        .rwDir     (rwDir),
        .startDet  (startDet),
        .stopDet   (stopDet),
        .nackRx    (nackRx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rxValid) begin
            rx_log[8'(n_rxv)] <= rxData;
            n_rxv <= n_rxv + 1;
        end
        if (txReq)    begin n_txr <= n_txr + 1; tx_idx <= tx_idx + 1; end
        if (startDet) n_start <= n_start + 1;
        if (stopDet)  n_stop <= n_stop + 1;
        if (nackRx)   n_nack <= n_nack + 1;
        if (I2C_SDA_o !== prev_sda && scl_line && !rst) n_viol <= n_viol + 1;
        if (!I2C_SDA_o) n_sda_low <= n_sda_low + 1;
        prev_sda <= I2C_SDA_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scl_high();
        int n = 0;
        scl_ctl = 1'b1;
        while (scl_line !== 1'b1 && n < 4000) begin
            wait_clk(1);
            n++;
        end
        if (n >= 4000) chk("scl_release_timeout", 32'(scl_line), 32'd1);
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        sda_ctl = b;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        seen = sda_line;
        wait_clk(Q);
        scl_ctl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        sda_ctl = 1'b0;
        wait_clk(Q);
        scl_ctl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0;
        wait_clk(Q);
        scl_high();
        wait_clk(Q);
        sda_ctl = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            d[i] = s;
        end
        bit_xfer(nack, s);
    endtask

    // One transaction: START, address, nb data bytes (reads end in NACK), optional STOP.
    task automatic xact(input logic [6:0] a, input logic rw, input int nb, input logic do_stop);
        logic       ack, hit;
        logic [7:0] d, got;
        int rxv0, txr0, st0, sp0, nk0, low0;
        hit  = (a == TGT);
        rxv0 = n_rxv; txr0 = n_txr; st0 = n_start; sp0 = n_stop; nk0 = n_nack; low0 = n_sda_low;
        i2c_start();
        send_byte({a, rw}, ack);
        chk("addr_ack", 32'(ack), 32'(hit ? I2C_ACK : I2C_NACK));
        chk("selected", 32'(selected), 32'(hit));
        if (hit) chk("rwDir", 32'(rwDir), 32'(rw));
        for (int i = 0; i < nb; i++) begin
            if (rw) begin
                recv_byte(i == nb - 1, got);
                chk($sformatf("rd_byte%0d", i), 32'(got), 32'(hit ? pool[8'(exp_ptr + i)] : 8'hFF));
            end else begin
                d = (wr_q.size() > 0) ? wr_q.pop_front() : 8'($urandom);
                send_byte(d, ack);
                chk("wr_ack", 32'(ack), 32'(hit ? I2C_ACK : I2C_NACK));
                if (hit) exp_rx.push_back(d);
            end
        end
        if (hit && rw) exp_ptr += nb;
        if (do_stop) i2c_stop();
        wait_clk(2);
        chk("rxValid_cnt", n_rxv - rxv0, (hit && !rw) ? nb : 0);
        chk("txReq_cnt", n_txr - txr0, (hit && rw) ? nb : 0);
        chk("nackRx_cnt", n_nack - nk0, (hit && rw) ? 1 : 0);
        chk("startDet_cnt", n_start - st0, 1);
        chk("stopDet_cnt", n_stop - sp0, do_stop ? 1 : 0);
        if (!hit) chk("miss_sda_low_cycles", n_sda_low - low0, 0);
        if (do_stop) chk("selected_after_stop", 32'(selected), 32'd0);
        while (exp_rx.size() > 0) begin
            chk("rxData_seq", 32'(rx_log[8'(rx_rd)]), 32'(exp_rx.pop_front()));
            rx_rd++;
        end
        rx_rd = n_rxv;
    endtask

    initial begin
        logic       s, ack;
        logic [6:0] a;
        rst = 1'b1; enable = 1'b1; txValid = 1'b1;
        scl_ctl = 1'b1; sda_ctl = 1'b1;
        for (int i = 0; i < 256; i++) pool[i] = 8'($urandom);
        pool[0] = 8'hA5;
        wait_clk(3);
        chk("rst_sda_o", 32'(I2C_SDA_o), 32'd1);
        chk("rst_scl_o", 32'(I2C_SCL_o), 32'd1);
        chk("rst_rxData", 32'(rxData), 32'd0);
        chk("rst_selected", 32'(selected), 32'd0);
        chk("rst_rwDir", 32'(rwDir), 32'd0);
        chk("rst_rxValid", 32'(rxValid), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        wr_q.push_back(8'h7D);
        xact(TGT, 1'b0, 1, 1'b1);
        chk("rxData_hold", 32'(rxData), 32'h7D);

        xact(TGT, 1'b1, 1, 1'b1);
        xact(7'h14, 1'b0, 2, 1'b1);

        wr_q.push_back(8'h05);
        xact(TGT, 1'b0, 1, 1'b0);
        xact(TGT, 1'b1, 3, 1'b1);
        chk("rxData_after_rs", 32'(rxData), 32'h05);

        // Abort a read four bits into its first data byte.
        i2c_start();
        send_byte({TGT, 1'b1}, ack);
        chk("abort_addr_ack", 32'(ack), 32'(I2C_ACK));
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
        rst = 1'b1;
        wait_clk(1);
        chk("midrst_sda_o", 32'(I2C_SDA_o), 32'd1);
        chk("midrst_scl_o", 32'(I2C_SCL_o), 32'd1);
        chk("midrst_selected", 32'(selected), 32'd0);
        chk("midrst_rxData", 32'(rxData), 32'd0);
        rst = 1'b0;
        exp_ptr += 1;
        wait_clk(4);
        xact(TGT, 1'b0, 2, 1'b1);

        for (int k = 0; k < 12; k++) begin
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
            xact(a, 1'($urandom), $urandom_range(1, 3), $urandom_range(0, 3) != 0);
        end
        i2c_stop();
        wait_clk(2);

        chk("sda_change_while_scl_high", n_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C peripheral-side (target) responder: the other end of the bus from the team's I2CController.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, ACKs it, then streams write bytes out to fabric or shifts read bytes in from fabric.
- Open-drain style outputs: 0 = pull low, 1 = release. Outputs connect straight to the pad/tristate logic alongside the controller.

Parameters:
- TARGET_ADDR, 7'h13, 7-bit address this target answers to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on I2C_SCL_i/I2C_SDA_i (min 2).

Ports:
- clk  in  1  system clock; must be >= 16x SCL frequency.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  0 = ignore the bus, release both lines, hold IDLE.
- I2C_SCL_i  in  1  SCL pad input.
- I2C_SDA_i  in  1  SDA pad input.
- I2C_SCL_o  out  1  SCL drive; 0 = stretch low; constant 1 unless I2C_TGT_STRETCH_EN.
- I2C_SDA_o  out  1  SDA drive; 0 = pull low, 1 = release.
- rxData  out  8  last byte written by the controller.
- rxValid  out  1  1-cycle pulse, rxData valid.
- txData  in  8  next read byte; sampled on the txReq cycle.
- txValid  in  1  txData ready; used only with I2C_TGT_STRETCH_EN.
- txReq  out  1  1-cycle pulse, txData consumed.
- selected  out  1  high from address ACK until STOP/START.
- rwDir  out  1  R/W bit of the current transfer (1 = read).
- startDet  out  1  pulse on START or repeated START.
- stopDet  out  1  pulse on STOP.
- nackRx  out  1  pulse when the controller NACKs a read byte.

Behaviour:
- Reset, on the first clk edge with rst=1: I2C_SCL_o=1, I2C_SDA_o=1, rxData=0, all pulses 0, selected=0, rwDir=0, state IDLE, synchronizers filled with 1. Applies mid-transfer, releasing the bus immediately.
- Edge detection uses synchronized values only:
  - scl_rise/scl_fall from consecutive samples.
  - START = SDA 1->0 while SCL high.
  - STOP = SDA 0->1 while SCL high.
- Timing: SDA is sampled on scl_rise. I2C_SDA_o changes only on the cycle after scl_fall, never while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE.
  - IDLE: START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits MSB first.
    - Bits [7:1] == TARGET_ADDR -> ADDR_ACK; latch rwDir.
    - Mismatch -> IGNORE.
    - For a read, txReq pulses and txData loads into the shift register on the 8th scl_rise.
  - ADDR_ACK: drive SDA low from the next scl_fall to the following scl_fall; selected=1. Then WRITE (rwDir=0) or READ (rwDir=1).
  - WRITE: shift 8 bits. On the 8th scl_rise, rxData updates and rxValid pulses the same cycle; then WRITE_ACK, which ACKs as in ADDR_ACK and returns to WRITE.
  - READ: present the shift-register MSB on each scl_fall (first bit at the ADDR_ACK/READ_ACK exit); release SDA after the 8th bit; then READ_ACK.
  - READ_ACK: sample SDA on scl_rise.
    - 0 (ACK): txReq pulses, next byte loads, -> READ.
    - 1 (NACK): nackRx pulses, -> IGNORE.
  - IGNORE: SDA released; waits for START or STOP.
- STOP in any state -> IDLE, stopDet pulses, selected=0, SDA released.
- START in any state, including mid-byte -> ADDR, startDet pulses, counter cleared.
- enable=0 behaves as a reset of the FSM only; rxData is held.
- rxData holds until the next write byte.
- A START and STOP can never occur in the same cycle; if both flags appear (glitch), STOP wins.

Optional Feature:
- Macro: I2C_TGT_STRETCH_EN.
- Defined: when a read byte is due (ADDR_ACK exit or READ_ACK with ACK) and txValid=0, hold I2C_SCL_o=0 from that scl_fall until txValid=1. txReq fires on that txValid cycle and SCL releases on the next cycle. In WRITE no stretching occurs.
- Undefined: I2C_SCL_o tied 1, txValid ignored, txData taken unconditionally at txReq.

Decomposition:
- Package i2c_pkg: state enum i2c_tgt_state_t, I2C_ACK=1'b0 / I2C_NACK=1'b1 constants, default address constant.
- One natural sub-module, i2c_bus_sync: synchronizers plus scl_rise/scl_fall/start/stop pulse generation. It is reusable by the controller.

Test Plan:
- Write: START, 0x26, ACK, 0x7D, STOP -> SDA low on both ACK bits; rxData=0x7D with a single rxValid pulse; stopDet pulses; selected falls.
- Read: START, 0x27, txData=0xA5, controller NACK -> ACK on address; SDA carries 1,0,1,0,0,1,0,1; txReq pulses exactly once; nackRx pulses; state IGNORE then IDLE after STOP.
- Address miss: START, 0x28 (addr 0x14) plus 2 data bytes -> I2C_SDA_o stays 1 throughout; no rxValid; selected stays 0.
- Repeated START: write 0x26, 0x05, then START, 0x27, ACK, ACK, NACK -> rxData=0x05; rwDir=1 after the second address; three txReq pulses (0xA5, then next txData values) appear on SDA.
- Reset mid-byte: assert rst after 4 data bits of a read -> both outputs 1 on the next clk; IDLE; the next full write transaction completes normally.
- Stretch (macro on): read with txValid=0 for 50 clk -> I2C_SCL_o low 50+1 cycles after the ACK scl_fall, then released; byte transmits correctly.
